// File: rtl/bs_gnrtr_n_rbtr_pkg.sv
// Shared types for the bus generator / arbiter.
// State encoding and destination-ID width used by every bus lane.
package bs_gnrtr_n_rbtr_pkg;

    localparam int ID_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        PUSH
    } bus_state_e;

endpackage

// File: rtl/bs_gnrtr_n_rbtr_lane.sv
// bus_lane_arbiter: one bus, round-robin source pick, pop then push.
// Outputs are gated by reset so an aborted transfer never pulses.
module bus_lane_arbiter
    import bs_gnrtr_n_rbtr_pkg::*;
#(
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [drvrs-1:0]                 pndng_i,
    input  logic [drvrs-1:0][pckg_sz-1:0]    d_pop_i,
    output logic [drvrs-1:0]                 pop_o,
    output logic [drvrs-1:0]                 push_o,
    output logic [pckg_sz-1:0]               d_push_o
);

    localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

    bus_state_e          state_q, state_d;
    logic [IW-1:0]       rr_q, rr_d;
    logic [IW-1:0]       src_q, src_d;
    logic [drvrs-1:0]    mask_q, mask_d;
    logic [pckg_sz-1:0]  dout_q, dout_d;

    logic                found;
    logic [IW-1:0]       pick;
    logic [ID_W-1:0]     id;
    logic [drvrs-1:0]    dmask;
    int                  j;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        j     = 0;
        for (int k = 0; k < drvrs; k++) begin
            j = int'(rr_q) + k;
            if (j >= drvrs) j = j - drvrs;
            if (!found && pndng_i[j]) begin
                found = 1'b1;
                pick  = IW'(j);
            end
        end
    end

    // Broadcast reaches everyone but the source; out-of-range IDs reach nobody.
    always_comb begin
        id = d_pop_i[src_q][pckg_sz-1 -: ID_W];
        for (int d = 0; d < drvrs; d++) begin
            if (id == broadcast) dmask[d] = (d != int'(src_q));
            else                 dmask[d] = (int'(id) == d);
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        src_d   = src_q;
        mask_d  = mask_q;
        dout_d  = dout_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    src_d   = pick;
                    state_d = POP;
                end
            end
            POP: begin
                mask_d  = dmask;
                if (|dmask) dout_d = d_pop_i[src_q];
                state_d = PUSH;
            end
            PUSH: begin
                rr_d    = (int'(src_q) == drvrs - 1) ? '0 : src_q + IW'(1);
                mask_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            src_q   <= '0;
            mask_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            src_q   <= src_d;
            mask_q  <= mask_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        for (int d = 0; d < drvrs; d++) begin
            pop_o[d] = (state_q == POP) && !reset && (int'(src_q) == d);
        end
        push_o   = (state_q == PUSH && !reset) ? mask_q : '0;
        d_push_o = dout_q;
    end

endmodule

// File: rtl/bs_gnrtr_n_rbtr.sv
// Multi-bus generator/arbiter: one independent bus_lane_arbiter per bus.
// Each lane's delivered packet is fanned out to all of its devices.
module bs_gnrtr_n_rbtr
    import bs_gnrtr_n_rbtr_pkg::*;
#(
    parameter int              bits      = 1,
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [bits-1:0][drvrs-1:0]                 pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]    D_pop,
    output logic [bits-1:0][drvrs-1:0]                 pop,
    output logic [bits-1:0][drvrs-1:0]                 push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]    D_push
);

    for (genvar g = 0; g < bits; g++) begin : g_bus
        logic [pckg_sz-1:0] dout;

        bus_lane_arbiter #(
            .drvrs     (drvrs),
            .pckg_sz   (pckg_sz),
            .broadcast (broadcast)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .pndng_i  (pndng[g]),
            .d_pop_i  (D_pop[g]),
            .pop_o    (pop[g]),
            .push_o   (push[g]),
            .d_push_o (dout)
        );

        for (genvar d = 0; d < drvrs; d++) begin : g_dev
            assign D_push[g][d] = dout;
        end
    end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// Bench for bs_gnrtr_n_rbtr (bits=1, drvrs=4, pckg_sz=16).
// Directed cases plus random traffic against a transaction-level model.
module tb_bs_gnrtr_n_rbtr;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [0:0][3:0]         pndng;
    logic [0:0][3:0][15:0]   D_pop;
    logic [0:0][3:0]         pop;
    logic [0:0][3:0]         push;
    logic [0:0][3:0][15:0]   D_push;

    int n_chk = 0;
    int n_fail = 0;

    bs_gnrtr_n_rbtr #(
        .bits      (1),
        .drvrs     (4),
        .pckg_sz   (16),
        .broadcast (8'hFF)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .D_pop  (D_pop),
        .pop    (pop),
        .push   (push),
        .D_push (D_push)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transaction model: a bus is busy for 3 edges per packet once it picks.
    int          m_busy;
    int          m_src;
    int          m_rr;
    logic [3:0]  e_pop, e_push;
    logic [15:0] e_dp;

    task automatic model_step();
        logic [15:0] pkt;
        logic [7:0]  id;
        e_pop  = '0;
        e_push = '0;
        if (reset) begin
            m_busy = 0;
            m_rr   = 0;
            e_dp   = '0;
        end else if (m_busy == 0) begin
            for (int k = 0; k < 4; k++) begin
                if (m_busy == 0 && pndng[0][(m_rr + k) % 4]) begin
                    m_src  = (m_rr + k) % 4;
                    m_busy = 2;
                    e_pop  = 4'(1 << m_src);
                end
            end
        end else if (m_busy == 2) begin
            pkt = D_pop[0][m_src];
            id  = pkt[15:8];
            if (id == 8'hFF)   e_push = 4'hF & ~4'(1 << m_src);
            else if (id < 4)   e_push = 4'(1 << id);
            if (e_push != 0)   e_dp = pkt;
            m_busy = 1;
        end else begin
            m_rr   = (m_src + 1) % 4;
            m_busy = 0;
        end
    endtask

    task automatic tick(input logic r, input logic [3:0] p,
                        input logic [3:0][15:0] d);
        reset    = r;
        pndng[0] = p;
        D_pop[0] = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("pop", pop[0], e_pop);
        chk("push", push[0], e_push);
        chk("dpush", D_push[0], {4{e_dp}});
    endtask

    function automatic logic [15:0] rnd_pkt();
        logic [7:0] id;
        case ($urandom_range(0, 5))
            0: id = 8'd0;
            1: id = 8'd1;
            2: id = 8'd2;
            3: id = 8'd3;
            4: id = 8'hFF;
            default: id = 8'($urandom_range(4, 254));
        endcase
        return {id, 8'($urandom)};
    endfunction

    logic [3:0][15:0] dp;
    logic [3:0]       rr_seen [15];
    logic [3:0]       rr_exp  [15];

    initial begin
        m_busy = 0; m_src = 0; m_rr = 0;
        e_pop = '0; e_push = '0; e_dp = '0;
        dp = '0;

        tick(1'b1, 4'hF, dp);
        tick(1'b1, 4'hF, dp);
        chk("rst_pop", pop[0], 4'h0);
        chk("rst_push", push[0], 4'h0);
        chk("rst_dpush", D_push[0], 64'h0);

        dp = '0;
        dp[1] = 16'h02A5;
        tick(1'b0, 4'b0010, dp);
        chk("uni_pop", pop[0], 4'b0010);
        tick(1'b0, 4'b0000, dp);
        chk("uni_push", push[0], 4'b0100);
        chk("uni_dpush", D_push[0][2], 16'h02A5);
        tick(1'b0, 4'b0000, dp);

        dp = '0;
        dp[0] = 16'hFF3C;
        tick(1'b0, 4'b0001, dp);
        chk("bc_pop", pop[0], 4'b0001);
        tick(1'b0, 4'b0000, dp);
        chk("bc_push", push[0], 4'b1110);
        chk("bc_dpush", D_push[0][3], 16'hFF3C);
        tick(1'b0, 4'b0000, dp);

        tick(1'b1, 4'h0, dp);
        for (int i = 0; i < 4; i++) dp[i] = {8'(3 - i), 8'(i)};
        for (int i = 0; i < 15; i++) begin
            tick(1'b0, 4'hF, dp);
            rr_seen[i] = pop[0];
            rr_exp[i]  = (i % 3 == 0) ? 4'(1 << ((i / 3) % 4)) : 4'h0;
        end
        for (int i = 0; i < 15; i++) chk("rr_order", rr_seen[i], rr_exp[i]);

        tick(1'b1, 4'h0, dp);
        dp = '0;
        dp[3] = 16'h0711;
        tick(1'b0, 4'b1000, dp);
        chk("inv_pop", pop[0], 4'b1000);
        tick(1'b0, 4'b0000, dp);
        chk("inv_push", push[0], 4'b0000);
        tick(1'b0, 4'b0000, dp);
        tick(1'b0, 4'b1001, dp);
        chk("inv_rr", pop[0], 4'b0001);
        tick(1'b0, 4'b0000, dp);
        tick(1'b0, 4'b0000, dp);

        dp = '0;
        dp[1] = 16'h0155;
        tick(1'b0, 4'b0010, dp);
        chk("mr_pop", pop[0], 4'b0010);
        reset = 1'b1;
        #1;
        chk("mr_gate", pop[0], 4'b0000);
        tick(1'b1, 4'b0010, dp);
        chk("mr_push", push[0], 4'b0000);
        tick(1'b0, 4'hF, dp);
        chk("mr_restart", pop[0], 4'b0001);

        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 4; d++) dp[d] = rnd_pkt();
            tick(($urandom_range(0, 39) == 0), 4'($urandom), dp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
